// File: rtl/amux_scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : amux_seq_pkg
//  Description : Shared types and constants for the analog-mux scan
//                sequencer: FSM state encoding, scan-table entry field
//                layout and a one-hot channel decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package amux_seq_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_DWELL = 2'd2
    } state_e;

    // Scan-table entry layout: [2:0] P idx, [3] P en, [6:4] N idx, [7] N en
    localparam int c_ENTRY_W   = 8;
    localparam int c_IDX_W     = 3;
    localparam int c_P_IDX_LSB = 0;
    localparam int c_P_EN_BIT  = 3;
    localparam int c_N_IDX_LSB = 4;
    localparam int c_N_EN_BIT  = 7;
    localparam int c_MAX_CH    = 1 << c_IDX_W;

    // Decode a channel index into a one-hot switch-enable vector
    function automatic logic [c_MAX_CH-1:0] onehot(input logic [c_IDX_W-1:0] idx);
        onehot = c_MAX_CH'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/amux_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : amux_scan_sequencer_if
//  Description : Bundle between the SPI register block (master side) and the
//                scan sequencer (slave side).
//                master -> slave : cfg_we, cfg_addr, cfg_data, len, dwell,
//                                  continuous, start, stop
//                slave -> master : mux_p, mux_n, cur_idx, busy, step, done,
//                                  cfg_err
//  Revision    : 1.0 - initial release
// ============================================================================
interface amux_scan_sequencer_if #(
    parameter int N_CH    = 8,
    parameter int DWELL_W = 16
);
    logic               cfg_we;
    logic [2:0]         cfg_addr;
    logic [7:0]         cfg_data;
    logic [2:0]         len;
    logic [DWELL_W-1:0] dwell;
    logic               continuous;
    logic               start;
    logic               stop;
    logic [N_CH-1:0]    mux_p;
    logic [N_CH-1:0]    mux_n;
    logic [2:0]         cur_idx;
    logic               busy;
    logic               step;
    logic               done;
    logic               cfg_err;

    modport master (
        output cfg_we, cfg_addr, cfg_data, len, dwell, continuous, start, stop,
        input  mux_p, mux_n, cur_idx, busy, step, done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, len, dwell, continuous, start, stop,
        output mux_p, mux_n, cur_idx, busy, step, done, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/amux_scan_sequencer_table.sv
`default_nettype none
// ============================================================================
//  Module      : amux_seq_table
//  Description : DEPTH x 8 scan-table register file. One synchronous write
//                port, one asynchronous read port. Reset clears every entry,
//                which leaves both switch banks disabled for all entries.
//  Ports       : clk, rst          clock / sync active-high reset
//                we_i, waddr_i,    write strobe, entry index, entry data
//                wdata_i
//                raddr_i, rdata_o  combinational read
//  Revision    : 1.0 - initial release
// ============================================================================
module amux_seq_table
    import amux_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 we_i,
    input  wire logic [c_IDX_W-1:0]   waddr_i,
    input  wire logic [c_ENTRY_W-1:0] wdata_i,
    input  wire logic [c_IDX_W-1:0]   raddr_i,
    output logic      [c_ENTRY_W-1:0] rdata_o
);

    logic [c_ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/amux_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : amux_scan_sequencer
//  Description : Autonomous scan scheduler for the analog mux P/N switch
//                banks. Walks table entries 0..len, opening all switches for
//                BBM clocks before driving each entry for max(dwell,1) clocks.
//  Ports       : clk  system clock
//                rst  synchronous reset, active-high
//                bus  amux_scan_sequencer_if.slave (config in, switch
//                     enables and status out)
//  Revision    : 1.0 - initial release
// ============================================================================
module amux_scan_sequencer
    import amux_seq_pkg::*;
#(
    parameter int N_CH    = 8,
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 16,
    parameter int BBM     = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    amux_scan_sequencer_if.slave  bus
);

    localparam logic [DWELL_W-1:0] c_BBM_LAST = DWELL_W'(BBM - 1);

    state_e               state_q, state_d;
    logic [c_IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [c_IDX_W-1:0]   len_q, len_d;
    logic                 cont_q, cont_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [DWELL_W-1:0]   dwell_last_q, dwell_last_d;
    logic [N_CH-1:0]      mux_p_q, mux_p_d;
    logic [N_CH-1:0]      mux_n_q, mux_n_d;
    logic                 busy_q, step_q, step_d, done_q, done_d, err_q;

    logic [c_ENTRY_W-1:0] w_entry;
    logic [c_MAX_CH-1:0]  w_p_oh, w_n_oh;
    logic                 w_tbl_we;

    // Table is only writable while idle; writes during a scan are dropped
    assign w_tbl_we = bus.cfg_we && (state_q == ST_IDLE);

    amux_seq_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_tbl_we),
        .waddr_i (bus.cfg_addr),
        .wdata_i (bus.cfg_data),
        .raddr_i (cur_idx_q),
        .rdata_o (w_entry)
    );

    assign w_p_oh = onehot(w_entry[c_P_IDX_LSB +: c_IDX_W]);
    assign w_n_oh = onehot(w_entry[c_N_IDX_LSB +: c_IDX_W]);

    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        len_d        = len_q;
        cont_d       = cont_q;
        cnt_d        = cnt_q;
        dwell_last_d = dwell_last_q;
        done_d       = 1'b0;
        step_d       = 1'b0;
        mux_p_d      = '0;
        mux_n_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_BREAK;
                    cur_idx_d    = '0;
                    cnt_d        = '0;
                    len_d        = bus.len;
                    cont_d       = bus.continuous;
                    // Store the terminal count so dwell==0 behaves as 1
                    dwell_last_d = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
                end
            end
            ST_BREAK: begin
                if (cnt_q == c_BBM_LAST) begin
                    state_d = ST_DWELL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DWELL: begin
                if (cnt_q == dwell_last_q) begin
                    cnt_d = '0;
                    if (cur_idx_q != len_q) begin
                        cur_idx_d = cur_idx_q + 1'b1;
                        state_d   = ST_BREAK;
                    end else if (cont_q) begin
                        cur_idx_d = '0;
                        state_d   = ST_BREAK;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort has priority over everything, including a same-cycle start
        if (bus.stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end

        // Outputs are registered from the next state so that the switch
        // enables line up exactly with the state they belong to. cur_idx does
        // not change on the BREAK->DWELL edge, so the table read is valid.
        if (state_d == ST_DWELL) begin
            mux_p_d = w_entry[c_P_EN_BIT] ? w_p_oh[N_CH-1:0] : '0;
            mux_n_d = w_entry[c_N_EN_BIT] ? w_n_oh[N_CH-1:0] : '0;
            step_d  = (state_q == ST_BREAK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_idx_q    <= '0;
            len_q        <= '0;
            cont_q       <= 1'b0;
            cnt_q        <= '0;
            dwell_last_q <= '0;
            mux_p_q      <= '0;
            mux_n_q      <= '0;
            busy_q       <= 1'b0;
            step_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            len_q        <= len_d;
            cont_q       <= cont_d;
            cnt_q        <= cnt_d;
            dwell_last_q <= dwell_last_d;
            mux_p_q      <= mux_p_d;
            mux_n_q      <= mux_n_d;
            busy_q       <= (state_d != ST_IDLE);
            step_q       <= step_d;
            done_q       <= done_d;
            err_q        <= bus.cfg_we && (state_q != ST_IDLE);
        end
    end

    assign bus.mux_p   = mux_p_q;
    assign bus.mux_n   = mux_n_q;
    assign bus.cur_idx = cur_idx_q;
    assign bus.busy    = busy_q;
    assign bus.step    = step_q;
    assign bus.done    = done_q;
    assign bus.cfg_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_amux_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_amux_scan_sequencer
//  Description : Scoreboard bench for amux_scan_sequencer. The stimulus
//                process pushes expected step/done/cfg_err events (with the
//                cycle they must appear in) into a queue; a negedge monitor
//                pops and compares on every event the DUT raises, and also
//                checks that switch enables hold steady through each dwell.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_amux_scan_sequencer;

    localparam int K_STEP = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] p;
        logic [7:0] n;
        logic [2:0] idx;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    ev_t  q[$];
    logic [7:0] hold_p = '0;
    logic [7:0] hold_n = '0;

    amux_scan_sequencer_if #(.N_CH(8), .DWELL_W(16)) bus ();

    amux_scan_sequencer #(
        .N_CH    (8),
        .DEPTH   (8),
        .DWELL_W (16),
        .BBM     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_STEP:  kname = "step";
            K_DONE:  kname = "done";
            default: kname = "cfg_err";
        endcase
    endfunction

    function automatic void exp_ev(input int k, input int c, input logic [7:0] p,
                                   input logic [7:0] n, input logic [2:0] i);
        ev_t e;
        e.kind = k; e.cyc = c; e.p = p; e.n = n; e.idx = i;
        q.push_back(e);
    endfunction

    task automatic pop_ev(input int kind);
        ev_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_%s: got event at cycle %0d, required none", kname(kind), cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.p != bus.mux_p || e.n != bus.mux_n ||
                (kind == K_STEP && e.idx != bus.cur_idx)) begin
                n_err++;
                $display("FAIL event_%s: got %s cyc=%0d p=%02h n=%02h idx=%0d, required %s cyc=%0d p=%02h n=%02h idx=%0d",
                         kname(e.kind), kname(kind), cyc, bus.mux_p, bus.mux_n, bus.cur_idx,
                         kname(e.kind), e.cyc, e.p, e.n, e.idx);
            end
        end
    endtask

    // Monitor: event scoreboard plus per-cycle hold / idle-quiet checks
    always @(negedge clk) begin
        if (bus.step)    pop_ev(K_STEP);
        if (bus.done)    pop_ev(K_DONE);
        if (bus.cfg_err) pop_ev(K_ERR);
        if (bus.step) begin
            hold_p = bus.mux_p;
            hold_n = bus.mux_n;
        end else if ((bus.mux_p | bus.mux_n) != 8'h00) begin
            n_vec++;
            if (bus.mux_p != hold_p || bus.mux_n != hold_n) begin
                n_err++;
                $display("FAIL dwell_hold: got p=%02h n=%02h at cycle %0d, required p=%02h n=%02h",
                         bus.mux_p, bus.mux_n, cyc, hold_p, hold_n);
            end
        end
        if (!bus.busy) begin
            n_vec++;
            if ((bus.mux_p | bus.mux_n) != 8'h00) begin
                n_err++;
                $display("FAIL idle_quiet: got p=%02h n=%02h while not busy at cycle %0d, required 00/00",
                         bus.mux_p, bus.mux_n, cyc);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [7:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic start_scan(input logic [2:0] l, input logic [15:0] dw,
                              input logic c, output int t0);
        bus.len = l; bus.dwell = dw; bus.continuous = c; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((bus.busy || q.size() != 0) && k < 200) begin
            tick();
            k++;
        end
        tick();
        n_vec++;
        if (k >= 200) begin
            n_err++;
            $display("FAIL %s_timeout: got busy=%0d pending=%0d after 200 cycles, required idle/0",
                     nm, bus.busy, q.size());
            q.delete();
        end
    endtask

    // Two-entry single pass: e0={P1,N2}, e1={P5,N0}, dwell=4
    task automatic expect_two_entry_pass(input int t0);
        exp_ev(K_STEP, t0 + 2,  8'h02, 8'h04, 3'd0);
        exp_ev(K_STEP, t0 + 8,  8'h20, 8'h01, 3'd1);
        exp_ev(K_DONE, t0 + 12, 8'h00, 8'h00, 3'd0);
    endtask

    initial begin
        int t0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.len = '0; bus.dwell = '0; bus.continuous = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0;

        // Reset
        rst = 1'b1;
        tick(); tick();
        chk("rst_mux_p",   32'(bus.mux_p),   32'h0);
        chk("rst_mux_n",   32'(bus.mux_n),   32'h0);
        chk("rst_cur_idx", 32'(bus.cur_idx), 32'h0);
        chk("rst_busy",    32'(bus.busy),    32'h0);
        chk("rst_step",    32'(bus.step),    32'h0);
        chk("rst_done",    32'(bus.done),    32'h0);
        chk("rst_cfg_err", 32'(bus.cfg_err), 32'h0);
        rst = 1'b0;
        tick();

        // Cleared table drives nothing
        start_scan(3'd0, 16'd1, 1'b0, t0);
        exp_ev(K_STEP, t0 + 2, 8'h00, 8'h00, 3'd0);
        exp_ev(K_DONE, t0 + 3, 8'h00, 8'h00, 3'd0);
        wait_idle("empty_table");

        // Single pass
        write_entry(3'd0, 8'hA9);
        write_entry(3'd1, 8'h8D);
        start_scan(3'd1, 16'd4, 1'b0, t0);
        expect_two_entry_pass(t0);
        wait_idle("single_pass");

        // Config guard and start while busy
        start_scan(3'd1, 16'd4, 1'b0, t0);
        exp_ev(K_STEP, t0 + 2,  8'h02, 8'h04, 3'd0);
        exp_ev(K_ERR,  t0 + 4,  8'h02, 8'h04, 3'd0);
        exp_ev(K_STEP, t0 + 8,  8'h20, 8'h01, 3'd1);
        exp_ev(K_DONE, t0 + 12, 8'h00, 8'h00, 3'd0);
        wait_cyc(t0 + 3);
        write_entry(3'd0, 8'h00);
        wait_cyc(t0 + 5);
        bus.len = 3'd0; bus.dwell = 16'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_idle("cfg_guard");
        start_scan(3'd1, 16'd4, 1'b0, t0);
        expect_two_entry_pass(t0);
        wait_idle("table_unchanged");

        // Continuous, then stop mid-dwell
        start_scan(3'd0, 16'd3, 1'b1, t0);
        exp_ev(K_STEP, t0 + 2,  8'h02, 8'h04, 3'd0);
        exp_ev(K_STEP, t0 + 7,  8'h02, 8'h04, 3'd0);
        exp_ev(K_STEP, t0 + 12, 8'h02, 8'h04, 3'd0);
        wait_cyc(t0 + 13);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stop_mux_p", 32'(bus.mux_p), 32'h0);
        chk("stop_mux_n", 32'(bus.mux_n), 32'h0);
        chk("stop_busy",  32'(bus.busy),  32'h0);
        chk("stop_done",  32'(bus.done),  32'h0);
        repeat (10) tick();
        chk("stop_pending", 32'(q.size()), 32'h0);

        // Disabled N leg
        write_entry(3'd0, 8'h0B);
        start_scan(3'd0, 16'd2, 1'b0, t0);
        exp_ev(K_STEP, t0 + 2, 8'h08, 8'h00, 3'd0);
        exp_ev(K_DONE, t0 + 4, 8'h00, 8'h00, 3'd0);
        wait_idle("disabled_leg");

        // dwell = 0 behaves as 1
        start_scan(3'd0, 16'd0, 1'b0, t0);
        exp_ev(K_STEP, t0 + 2, 8'h08, 8'h00, 3'd0);
        exp_ev(K_DONE, t0 + 3, 8'h00, 8'h00, 3'd0);
        wait_idle("dwell_zero");

        // start and stop together: stop wins
        bus.len = 3'd0; bus.dwell = 16'd1; bus.continuous = 1'b0;
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("startstop_busy", 32'(bus.busy), 32'h0);
        repeat (5) tick();
        chk("startstop_busy_later", 32'(bus.busy), 32'h0);

        // rst mid-dwell, then table must be cleared
        write_entry(3'd0, 8'hA9);
        start_scan(3'd0, 16'd4, 1'b0, t0);
        exp_ev(K_STEP, t0 + 2, 8'h02, 8'h04, 3'd0);
        wait_cyc(t0 + 3);
        rst = 1'b1;
        tick();
        chk("midrst_mux_p", 32'(bus.mux_p), 32'h0);
        chk("midrst_mux_n", 32'(bus.mux_n), 32'h0);
        chk("midrst_busy",  32'(bus.busy),  32'h0);
        rst = 1'b0;
        tick();
        start_scan(3'd0, 16'd1, 1'b0, t0);
        exp_ev(K_STEP, t0 + 2, 8'h00, 8'h00, 3'd0);
        exp_ev(K_DONE, t0 + 3, 8'h00, 8'h00, 3'd0);
        wait_idle("table_cleared");

        chk("final_pending", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
